multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control sequencer for the multicycle MIPS datapath: a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives every write enable and mux select of the shared ALU, PC, IR, register file and unified memory. It waits on a memory ready handshake and flags illegal opcodes. It sits inside `CPU` between the instruction register's opcode field and the datapath control inputs.

## Interface
- `STATE_W`, 4, width of state register (fixed; listed for bench probing)
- `clock` in 1: single clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-high; forces state to FETCH
- `opcode` in 6: IR[31:26], valid from DECODE onward
- `zero` in 1: ALU zero flag, used only in BRANCH
- `mem_ready` in 1: memory has completed the current read/write this cycle
- `pc_write` out 1, `pc_write_cond` out 1, `pc_source` out 2
- `i_or_d` out 1 (0 = PC address, 1 = ALUOut address), `mem_read` out 1, `mem_write` out 1, `ir_write` out 1
- `alu_src_a` out 1, `alu_src_b` out 2, `alu_op` out 2
- `reg_write` out 1, `reg_dst` out 1, `mem_to_reg` out 1
- `retire` out 1: one-cycle pulse on an instruction's final cycle
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode
- `state` out 4: current state, for debug

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11
- Any encoding outside 0-11 goes to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE when `mem_ready`, else stay.
  - DECODE→MEMADR (LW/SW), EXEC (R), BRANCH (BEQ), JUMP (J), ADDIEX (ADDI), FETCH (other, with `illegal_op`=1 that cycle).
  - MEMADR→MEMRD (LW) or MEMWR (SW).
  - MEMRD→MEMWB when `mem_ready`, else stay.
  - MEMWR→FETCH when `mem_ready`, else stay.
  - EXEC→RWB, ADDIEX→ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH, JUMP→FETCH.
- Outputs not listed for a state are 0.
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00; ir_write=pc_write=`mem_ready`.
  - DECODE: alu_src_b=11, alu_op=00.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_read=1, i_or_d=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEMWR: mem_write=1, i_or_d=1.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - RWB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
- `retire`=1 in MEMWB, RWB, ADDIWB, BRANCH, JUMP, and in MEMWR when `mem_ready`.
- `zero` is not consumed internally; the datapath ANDs it with `pc_write_cond`.

## Timing
- `reset` high: state=FETCH immediately, without waiting for a clock edge.
- While `reset` is high, all write enables (`pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_write`) and `retire`/`illegal_op` are forced 0. Other outputs take their FETCH values.
- Reset asserted mid-instruction: the instruction is abandoned and no further writes occur. The first FETCH after release behaves as a normal fetch.
- Outputs are combinational from state, plus `mem_ready`/`opcode` where stated. No output register is added, so there is zero latency from a state change.
- Latency in cycles with `mem_ready` tied 1: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each cycle `mem_ready`=0 in FETCH/MEMRD/MEMWR adds one cycle. `mem_read`/`mem_write` and `i_or_d` are held stable throughout the wait.
- `opcode` changing outside DECODE has no effect on transitions.

## Test plan
- Reset: assert `reset` mid-EXEC asynchronously → `state`=0 before the next edge, `reg_write`=0; release → FETCH with `ir_write`=1 when `mem_ready`=1.
- Sequence R, LW, SW, BEQ, J, ADDI with `mem_ready`=1 → `retire` pulses at cycles 4, 9, 13, 16, 19, 23. Per-state outputs match the Operation list exactly.
- LW with `mem_ready` low for 3 cycles in MEMRD → stays in state 3 for 4 cycles with `mem_read`=1, `i_or_d`=1 throughout; total latency 8.
- SW with `mem_ready` low 2 cycles → `mem_write` held 3 cycles, single `retire` on the ready cycle, no `reg_write`.
- opcode 111111 → DECODE asserts `illegal_op` for 1 cycle, next state FETCH, no write enables asserted.
- FETCH with `mem_ready`=0 for 5 cycles → `pc_write`=`ir_write`=0 throughout; both assert in the cycle `mem_ready` rises.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control sequencer for the multicycle MIPS datapath. Outputs decode the current state with no added latency.
// Waits in FETCH/MEMRD/MEMWR until mem_ready; reset forces FETCH at once and masks every write enable.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               retire,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    state_t r_state;
    // LW/SW choice is captured in DECODE so later opcode changes cannot steer MEMADR.
    logic   r_is_sw;

    logic       w_pc_write, w_pc_write_cond, w_ir_write, w_reg_write, w_mem_write;
    logic       w_retire, w_illegal;
    logic       w_legal;
    logic       w_unused_zero;

    assign w_unused_zero = zero;
    assign w_legal = (opcode == OP_R)   || (opcode == OP_LW) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ) || (opcode == OP_J)  || (opcode == OP_ADDI);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_is_sw <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_is_sw <= (opcode == OP_SW);
                    case (opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= r_is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_RWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_write     = 1'b0;
        w_retire        = 1'b0;
        w_illegal       = 1'b0;
        pc_source       = 2'b00;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                w_illegal = ~w_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
                w_retire    = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
                w_retire    = 1'b1;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                w_pc_write_cond = 1'b1;
                pc_source       = 2'b01;
                w_retire        = 1'b1;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                pc_source  = 2'b10;
                w_retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write      = w_pc_write      & ~reset;
    assign pc_write_cond = w_pc_write_cond & ~reset;
    assign ir_write      = w_ir_write      & ~reset;
    assign reg_write     = w_reg_write     & ~reset;
    assign mem_write     = w_mem_write     & ~reset;
    assign retire        = w_retire        & ~reset;
    assign illegal_op    = w_illegal       & ~reset;
    assign state         = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into its expected state trace and checked cycle by cycle.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, retire, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;

    multicycle_control #(.STATE_W(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .retire(retire), .illegal_op(illegal_op), .state(state)
    );

    always #5 clock = ~clock;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ret_q[$];

    logic [18:0] got_ctrl;
    assign got_ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                       alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, retire, illegal_op};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    // Control word expected for a state, straight from the per-state output table.
    function automatic logic [18:0] exp_ctrl(input int s, input bit mr, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, irw, asa, rw, rd, m2r, ret, ill;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, iord, mrd, mwr, irw, asa, rw, rd, m2r, ret, ill} = '0;
        {pcs, asb, aop} = '0;
        case (s)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  begin asb = 2'b11; ill = !is_legal(op); end
            2, 10: begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; ret = 1; end
            5:  begin mwr = 1; iord = 1; ret = mr; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; ret = 1; end
            11: begin rw = 1; ret = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; ret = 1; end
            9:  begin pcw = 1; pcs = 2'b10; ret = 1; end
            default: ;
        endcase
        return {pcw, pcwc, pcs, iord, mrd, mwr, irw, asa, asb, aop, rw, rd, m2r, ret, ill};
    endfunction

    // Expands one instruction into its cycle-by-cycle state path, then drives and checks it.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        int st[$];
        bit mr[$];
        for (int i = 0; i < wf; i++) begin st.push_back(0); mr.push_back(0); end
        st.push_back(0); mr.push_back(1);
        st.push_back(1); mr.push_back(1'($urandom));
        case (op)
            OP_LW: begin
                st.push_back(2); mr.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin st.push_back(3); mr.push_back(0); end
                st.push_back(3); mr.push_back(1);
                st.push_back(4); mr.push_back(1'($urandom));
            end
            OP_SW: begin
                st.push_back(2); mr.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin st.push_back(5); mr.push_back(0); end
                st.push_back(5); mr.push_back(1);
            end
            OP_R:    begin st.push_back(6);  mr.push_back(1'($urandom)); st.push_back(7);  mr.push_back(1'($urandom)); end
            OP_ADDI: begin st.push_back(10); mr.push_back(1'($urandom)); st.push_back(11); mr.push_back(1'($urandom)); end
            OP_BEQ:  begin st.push_back(8);  mr.push_back(1'($urandom)); end
            OP_J:    begin st.push_back(9);  mr.push_back(1'($urandom)); end
            default: ;
        endcase
        foreach (st[k]) begin
            @(negedge clock);
            mem_ready = mr[k];
            zero      = 1'($urandom);
            opcode    = (st[k] == 1) ? op : 6'($urandom);
            #1;
            cyc++;
            if (retire) ret_q.push_back(cyc);
            check_eq("state", 32'(state), 32'(st[k]));
            check_eq("ctrl", 32'(got_ctrl), 32'(exp_ctrl(st[k], mr[k], op)));
        end
    endtask

    initial begin
        logic [5:0] seq_ops [6];
        int         seq_ret [6];
        logic [5:0] op;
        seq_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        seq_ret = '{4, 9, 13, 16, 19, 23};

        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h0; zero = 1'b0;
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_ctrl", 32'(got_ctrl), 32'(exp_ctrl(0, 1'b1, 6'h0) & 19'b0011011001111000000));
        @(negedge clock);
        reset = 1'b0; mem_ready = 1'b0;

        // Straight-line sequence with memory always ready: fixed retire cycles.
        cyc = 0; ret_q.delete();
        foreach (seq_ops[i]) run_instr(seq_ops[i], 0, 0);
        check_eq("seq_retire_cnt", 32'(ret_q.size()), 32'd6);
        foreach (seq_ret[i])
            if (i < ret_q.size()) check_eq("seq_retire_cyc", 32'(ret_q[i]), 32'(seq_ret[i]));

        // Stalled memory cases and an illegal opcode.
        cyc = 0;
        run_instr(OP_LW, 0, 3);
        check_eq("lw_stall_latency", 32'(cyc), 32'd8);
        ret_q.delete(); cyc = 0;
        run_instr(OP_SW, 0, 2);
        check_eq("sw_stall_retires", 32'(ret_q.size()), 32'd1);
        check_eq("sw_stall_latency", 32'(cyc), 32'd6);
        run_instr(OP_R, 5, 0);
        ret_q.delete(); cyc = 0;
        run_instr(6'b111111, 0, 0);
        check_eq("illegal_latency", 32'(cyc), 32'd2);
        check_eq("illegal_retires", 32'(ret_q.size()), 32'd0);

        // Asynchronous reset in the middle of EXEC.
        @(negedge clock); mem_ready = 1'b1; opcode = OP_R;
        @(negedge clock); #1;
        check_eq("pre_rst_decode", 32'(state), 32'd1);
        @(negedge clock); #1;
        check_eq("pre_rst_exec", 32'(state), 32'd6);
        #1 reset = 1'b1;
        #1;
        check_eq("async_rst_state", 32'(state), 32'd0);
        check_eq("async_rst_regw", 32'(reg_write), 32'd0);
        check_eq("async_rst_ctrl", 32'(got_ctrl), 32'(exp_ctrl(0, 1'b1, 6'h0) & 19'b0011011001111000000));
        @(negedge clock); #1;
        check_eq("held_rst_state", 32'(state), 32'd0);
        check_eq("held_rst_irw", 32'(ir_write), 32'd0);
        @(negedge clock);
        reset = 1'b0; mem_ready = 1'b1;
        #1;
        check_eq("rel_ir_write", 32'(ir_write), 32'd1);
        check_eq("rel_pc_write", 32'(pc_write), 32'd1);
        mem_ready = 1'b0;
        #1;
        check_eq("rel_ir_write_wait", 32'(ir_write), 32'd0);

        // Randomized instruction mix with random memory stalls.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
